regfile_rd_seq: RTL and testbench

//  Operand-fetch sequencer for the single-read-port register file (32x32, write port + async read port).

---
 rtl/regfile_rd_seq_pkg.sv | 15 +
 rtl/regfile_rd_capture.sv | 61 ++++++
 rtl/regfile_rd_seq.sv | 137 +++++++++++++
 tb/tb_regfile_rd_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_rd_seq_pkg.sv
// Shared definitions for the register-file operand-fetch sequencer.
// The REGFILE_BYPASS_EN build option is handled in regfile_rd_seq and regfile_rd_capture.
package regfile_rd_seq_pkg;

  localparam int unsigned XlenDefault = 32;
  localparam int unsigned AwDefault   = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd1  = 2'd1,
    StRd2  = 2'd2,
    StResp = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_rd_capture.sv
// One operand register: x0 masking on capture, optional write-port bypass.
// Build option REGFILE_BYPASS_EN enables forwarding of snooped writes.
module regfile_rd_capture #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5,
  parameter bit          ZERO_X0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cap_en_i,
`ifdef REGFILE_BYPASS_EN
  input  logic            upd_en_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
`endif
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] cap_data;
`ifdef REGFILE_BYPASS_EN
  logic            wr_hit;

  // Writes to x0 never forward; the array ignores them architecturally.
  assign wr_hit = wr_en_i && (wr_addr_i == addr_i) && (wr_addr_i != '0);
`endif

  always_comb begin
    sel_data = rdata_i;
`ifdef REGFILE_BYPASS_EN
    if (wr_hit) begin
      sel_data = wr_data_i;
    end
`endif
    cap_data = (ZERO_X0 && (addr_i == '0)) ? '0 : sel_data;

    q_d = q_q;
    if (cap_en_i) begin
      q_d = cap_data;
`ifdef REGFILE_BYPASS_EN
    end else if (upd_en_i && wr_hit) begin
      q_d = wr_data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_rd_seq.sv
// Operand-fetch sequencer: two reads on one regfile read port, one response.
// Build option REGFILE_BYPASS_EN forwards snooped writes into captured operands.
module regfile_rd_seq
  import regfile_rd_seq_pkg::*;
#(
  parameter int unsigned XLEN    = XlenDefault,
  parameter int unsigned AW      = AwDefault,
  parameter bit          ZERO_X0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [AW-1:0]   req_rs1_i,
  input  logic [AW-1:0]   req_rs2_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rs1_data_o,
  output logic [XLEN-1:0] rsp_rs2_data_o,
  output logic [AW-1:0]   rf_raddr_o,
  input  logic [XLEN-1:0] rf_rdata_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  state_e        state_q, state_d;
  logic [AW-1:0] rs1_q, rs1_d;
  logic [AW-1:0] rs2_q, rs2_d;
  logic          req_ready_q, req_ready_d;
  logic          cap1_en, cap2_en;

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rf_raddr_o = '0;
    cap1_en    = 1'b0;
    cap2_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          rs1_d   = req_rs1_i;
          rs2_d   = req_rs2_i;
          state_d = StRd1;
        end
      end
      StRd1: begin
        rf_raddr_o = rs1_q;
        cap1_en    = 1'b1;
        // Identical addresses share the single read.
        if (rs1_q == rs2_q) begin
          cap2_en = 1'b1;
          state_d = StResp;
        end else begin
          state_d = StRd2;
        end
      end
      StRd2: begin
        rf_raddr_o = rs2_q;
        cap2_en    = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rs1_q       <= '0;
      rs2_q       <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = (state_q == StResp);

`ifdef REGFILE_BYPASS_EN
  logic upd_en;
  assign upd_en = (state_q == StResp);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  regfile_rd_capture #(
    .XLEN    (XLEN),
    .AW      (AW),
    .ZERO_X0 (ZERO_X0)
  ) u_cap_rs1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .cap_en_i  (cap1_en),
`ifdef REGFILE_BYPASS_EN
    .upd_en_i  (upd_en),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
`endif
    .addr_i    (rs1_q),
    .rdata_i   (rf_rdata_i),
    .q_o       (rsp_rs1_data_o)
  );

  regfile_rd_capture #(
    .XLEN    (XLEN),
    .AW      (AW),
    .ZERO_X0 (ZERO_X0)
  ) u_cap_rs2 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .cap_en_i  (cap2_en),
`ifdef REGFILE_BYPASS_EN
    .upd_en_i  (upd_en),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
`endif
    .addr_i    (rs2_q),
    .rdata_i   (rf_rdata_i),
    .q_o       (rsp_rs2_data_o)
  );

endmodule

// File: tb/tb_regfile_rd_seq.sv
// Self-checking bench for regfile_rd_seq with a behavioural regfile and operand model.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_rd_seq;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [AW-1:0]   req_rs1 = '0;
  logic [AW-1:0]   req_rs2 = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_rs1_data;
  logic [XLEN-1:0] rsp_rs2_data;
  logic [AW-1:0]   rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [XLEN-1:0] wr_data = '0;

  int errors = 0;
  int checks = 0;

  // Environment regfile: async read, write on rising edge.
  logic [XLEN-1:0] rf_mem [32];
  // Architectural view used to compute expected operands.
  logic [XLEN-1:0] model_rf [32];

  assign rf_rdata = rf_mem[rf_raddr];
  always @(posedge clk) if (wr_en) rf_mem[wr_addr] <= wr_data;

  always #5 clk = ~clk;

  regfile_rd_seq #(
    .XLEN    (XLEN),
    .AW      (AW),
    .ZERO_X0 (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_rs1_i      (req_rs1),
    .req_rs2_i      (req_rs2),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rs1_data_o (rsp_rs1_data),
    .rsp_rs2_data_o (rsp_rs2_data),
    .rf_raddr_o     (rf_raddr),
    .rf_rdata_i     (rf_rdata),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data)
  );

  function automatic logic [XLEN-1:0] model_rd(input logic [AW-1:0] a);
    return (a == '0) ? '0 : model_rf[a];
  endfunction

  // All tasks begin and end just after a falling edge.
  task automatic rf_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
    model_rf[a] = d;
  endtask

  task automatic start_req(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                           input bit coll, input logic [XLEN-1:0] coll_data);
    int n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_wait: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_rs1 = AW'($urandom); req_rs2 = AW'($urandom);
    checks++;
    if (rf_raddr !== rs1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd1_cycle: got raddr=%0d valid=%b ready=%b want raddr=%0d valid=0 ready=0",
               rf_raddr, rsp_valid, req_ready, rs1);
    end
    if (coll) begin
      wr_en = 1'b1; wr_addr = rs1; wr_data = coll_data;
    end
    if (rs1 != rs2) begin
      @(posedge clk); @(negedge clk);
      if (coll) begin wr_en = 1'b0; model_rf[rs1] = coll_data; end
      checks++;
      if (rf_raddr !== rs2 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd2_cycle: got raddr=%0d valid=%b want raddr=%0d valid=0",
                 rf_raddr, rsp_valid, rs2);
      end
    end
    @(posedge clk); @(negedge clk);
    if (coll && rs1 == rs2) begin wr_en = 1'b0; model_rf[rs1] = coll_data; end
    checks++;
    if (rsp_valid !== 1'b1 || rf_raddr !== '0 || rsp_rs1_data !== e1 || rsp_rs2_data !== e2) begin
      errors++;
      $display("FAIL rsp_entry: got valid=%b raddr=%0d d1=%h d2=%h want valid=1 raddr=0 d1=%h d2=%h",
               rsp_valid, rf_raddr, rsp_rs1_data, rsp_rs2_data, e1, e2);
    end
  endtask

  // Holds the response, scribbling unrelated registers, then drains it.
  task automatic finish_rsp(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input int hold,
                            input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
    logic [AW-1:0] a;
    for (int i = 0; i < hold; i++) begin
      do a = AW'($urandom); while (a == rs1 || a == rs2);
      rf_write(a, $urandom);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rs1_data !== e1 || rsp_rs2_data !== e2) begin
        errors++;
        $display("FAIL rsp_hold: got valid=%b d1=%h d2=%h want valid=1 d1=%h d2=%h",
                 rsp_valid, rsp_rs1_data, rsp_rs2_data, e1, e2);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_drain: got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic txn(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input int hold);
    logic [XLEN-1:0] e1, e2;
    e1 = model_rd(rs1);
    e2 = model_rd(rs2);
    start_req(rs1, rs2, e1, e2, 1'b0, '0);
    finish_rsp(rs1, rs2, hold, e1, e2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rs1_data !== '0 ||
        rsp_rs2_data !== '0 || rf_raddr !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b d1=%h d2=%h raddr=%0d want all 0",
               req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, rf_raddr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL ready_at_release: got %b want 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_release: got %b want 1", req_ready);
    end
    for (int i = 0; i < 32; i++) rf_write(AW'(i), $urandom);
  endtask

  task automatic test_two_reads();
    rf_write(5'd3, 32'h11);
    rf_write(5'd7, 32'h22);
    txn(5'd3, 5'd7, 2);
  endtask

  task automatic test_same_reg();
    rf_write(5'd5, 32'hA5);
    txn(5'd5, 5'd5, 1);
  endtask

  task automatic test_x0();
    rf_write(5'd0, 32'hDEAD);
    txn(5'd0, 5'd0, 0);
    txn(5'd0, 5'd3, 0);
  endtask

  task automatic test_write_during_rsp();
    logic [XLEN-1:0] e2;
    start_req(5'd3, 5'd7, 32'h11, 32'h22, 1'b0, '0);
    e2 = 32'h22;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        rf_write(5'd7, 32'h99);
`ifdef REGFILE_BYPASS_EN
        e2 = 32'h99;
`endif
      end else begin
        @(posedge clk); @(negedge clk);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h11 || rsp_rs2_data !== e2) begin
        errors++;
        $display("FAIL rsp_snoop: got valid=%b d1=%h d2=%h want valid=1 d1=11 d2=%h",
                 rsp_valid, rsp_rs1_data, rsp_rs2_data, e2);
      end
    end
    finish_rsp(5'd3, 5'd7, 0, 32'h11, e2);
  endtask

  task automatic test_write_collision();
    logic [XLEN-1:0] e1, e2;
    rf_write(5'd9, 32'h1234_5678);
    rf_write(5'd10, 32'h0BAD_F00D);
`ifdef REGFILE_BYPASS_EN
    e1 = 32'hCAFE_0009;
`else
    e1 = 32'h1234_5678;
`endif
    e2 = 32'h0BAD_F00D;
    start_req(5'd9, 5'd10, e1, e2, 1'b1, 32'hCAFE_0009);
    finish_rsp(5'd9, 5'd10, 1, e1, e2);
    // Array now holds the written value regardless of forwarding.
    txn(5'd9, 5'd9, 0);
  endtask

  task automatic test_reset_mid_op();
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd7;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rf_raddr !== 5'd7) begin
      errors++; $display("FAIL pre_reset_rd2: got raddr=%0d want 7", rf_raddr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rf_raddr !== '0 ||
        rsp_rs1_data !== '0 || rsp_rs2_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: got ready=%b valid=%b raddr=%0d d1=%h d2=%h want all 0",
               req_ready, rsp_valid, rf_raddr, rsp_rs1_data, rsp_rs2_data);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(5'd3, 5'd7, 1);
  endtask

  task automatic test_random();
    logic [AW-1:0] rs1, rs2;
    for (int i = 0; i < 40; i++) begin
      rs1 = AW'($urandom);
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : AW'($urandom);
      if ($urandom_range(0, 2) == 0) rf_write(rs2, $urandom);
      txn(rs1, rs2, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_two_reads();
    test_same_reg();
    test_x0();
    test_write_during_rsp();
    test_write_collision();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
